// File: rtl/pipelined_risc_v_core_p.sv
// Three-stage (fetch / execute / writeback) RV32I-subset core with a byte-wide
// program loader; the pipeline freezes and the loader opens while run is low.
module pipelined_risc_v_core_p #(
    parameter int WIDTH = 8,
    parameter int NREG  = 16,
    parameter int PM_AW = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic             load_valid,
    input  logic [7:0]       load_byte,
    output logic             load_ready,
    output logic [PM_AW-1:0] pc,
    output logic [WIDTH-1:0] result,
    output logic             wb_valid,
    output logic             halted
);
    localparam int RA  = $clog2(NREG);
    localparam int SHW = $clog2(WIDTH);
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [2:0] {K_NOP, K_ALU, K_BEQ, K_BNE, K_HALT} kind_e;
    typedef enum logic [2:0] {A_ADD, A_SUB, A_SLL, A_XOR, A_SRL, A_OR, A_AND} alu_e;

    typedef struct packed {
        kind_e            kind;
        alu_e             alu;
        logic             use_imm;
        logic [RA-1:0]    rd;
        logic [RA-1:0]    rs1;
        logic [RA-1:0]    rs2;
        logic [WIDTH-1:0] imm;
        logic [PM_AW-1:0] target;
    } dec_t;

    logic [31:0]                pm [2**PM_AW];
    logic [31:0]                ir;
    logic [PM_AW-1:0]           pc_q;
    logic [NREG-1:0][WIDTH-1:0] rf;
    logic [WIDTH-1:0]           wb_val;
    logic [RA-1:0]              wb_rd;
    logic                       wb_we;
    logic                       halt_q;
    logic [PM_AW-1:0]           load_addr;
    logic [1:0]                 bcnt;
    logic [23:0]                lbuf;

    dec_t             d;
    logic [31:0]      imm32;
    logic [WIDTH-1:0] a, src2, b, alu_out;
    logic             taken, wr_en;

    // ---------------- decode ----------------
    always_comb begin
        imm32    = {{20{ir[31]}}, ir[31:20]};
        d        = '0;
        d.kind   = K_NOP;
        d.alu    = A_ADD;
        d.rd     = ir[7 +: RA];
        d.rs1    = ir[15 +: RA];
        d.rs2    = ir[20 +: RA];
        d.imm    = imm32[WIDTH-1:0];
        d.target = ir[25 +: PM_AW];
        case (ir[6:0])
            7'b0110011: begin
                d.kind = K_ALU;
                case (ir[14:12])
                    3'b000: begin
                        if (ir[31:25] == 7'b0000000)      d.alu = A_ADD;
                        else if (ir[31:25] == 7'b0100000) d.alu = A_SUB;
                        else                              d.kind = K_NOP;
                    end
                    3'b001:  d.alu = A_SLL;
                    3'b100:  d.alu = A_XOR;
                    3'b101:  d.alu = A_SRL;
                    3'b110:  d.alu = A_OR;
                    3'b111:  d.alu = A_AND;
                    default: d.kind = K_NOP;
                endcase
            end
            7'b0010011: begin
                if (ir[14:12] == 3'b000) begin
                    d.kind    = K_ALU;
                    d.use_imm = 1'b1;
                end
            end
            7'b1100011: begin
                if (ir[14:12] == 3'b000)      d.kind = K_BEQ;
                else if (ir[14:12] == 3'b001) d.kind = K_BNE;
            end
            7'b1111111: d.kind = K_HALT;
            default: ;
        endcase
    end

    // ---------------- execute: operand forward, ALU, branch ----------------
    // wb_we is never set for rd=0, so x0 can never be forwarded.
    always_comb begin
        a    = (wb_we && wb_rd == d.rs1) ? wb_val : rf[d.rs1];
        src2 = (wb_we && wb_rd == d.rs2) ? wb_val : rf[d.rs2];
        b    = d.use_imm ? d.imm : src2;
        case (d.alu)
            A_ADD:   alu_out = a + b;
            A_SUB:   alu_out = a - b;
            A_SLL:   alu_out = a << b[SHW-1:0];
            A_XOR:   alu_out = a ^ b;
            A_SRL:   alu_out = a >> b[SHW-1:0];
            A_OR:    alu_out = a | b;
            A_AND:   alu_out = a & b;
            default: alu_out = a + b;
        endcase
        taken = (d.kind == K_BEQ && a == src2) || (d.kind == K_BNE && a != src2);
        wr_en = (d.kind == K_ALU) && (d.rd != '0);
    end

    // ---------------- pipeline state ----------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            pc_q   <= '0;
            ir     <= NOP;
            rf     <= '0;
            wb_val <= '0;
            wb_rd  <= '0;
            wb_we  <= 1'b0;
            halt_q <= 1'b0;
        end else if (run) begin
            if (wb_we) rf[wb_rd] <= wb_val;
            wb_we <= wr_en;
            // WB register keeps its last written value across non-writing ops
            if (wr_en) begin
                wb_val <= alu_out;
                wb_rd  <= d.rd;
            end
            if (d.kind == K_HALT) begin
                halt_q <= 1'b1;
                ir     <= NOP;
            end else if (taken) begin
                pc_q <= d.target;
                ir   <= NOP;
            end else if (!halt_q) begin
                ir   <= pm[pc_q];
                pc_q <= pc_q + PM_AW'(1);
            end
        end
    end

    // ---------------- program loader ----------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            load_addr <= '0;
            bcnt      <= '0;
            lbuf      <= '0;
        end else if (run) begin
            bcnt <= '0;
        end else if (load_valid) begin
            case (bcnt)
                2'd0:    lbuf[7:0]   <= load_byte;
                2'd1:    lbuf[15:8]  <= load_byte;
                2'd2:    lbuf[23:16] <= load_byte;
                default: load_addr   <= load_addr + PM_AW'(1);
            endcase
            bcnt <= bcnt + 2'd1;
        end
    end

    // Program memory has no reset so a loaded program survives rst.
    always_ff @(posedge clk) begin
        if (rst && !run && load_valid && bcnt == 2'd3)
            pm[load_addr] <= {load_byte, lbuf};
    end

    logic unused_bits;
    assign unused_bits = ^{ir, imm32};

    assign load_ready = !run;
    assign pc         = pc_q;
    assign result     = wb_val;
    assign wb_valid   = run & wb_we;
    assign halted     = halt_q;

endmodule

// File: tb/tb_pipelined_risc_v_core_p.sv
// Bench for pipelined_risc_v_core_p: directed programs plus random programs,
// all scored against an instruction-level interpreter of the ISA.
module tb_pipelined_risc_v_core_p;
    localparam int W  = 8;
    localparam int NR = 16;
    localparam int AW = 7;
    localparam logic [31:0] HALT = 32'h0000_007F;

    logic          clk = 1'b0, rst = 1'b0, run = 1'b0, load_valid = 1'b0;
    logic [7:0]    load_byte = 8'h00;
    logic          load_ready, wb_valid, halted;
    logic [AW-1:0] pc;
    logic [W-1:0]  result;

    int           n_chk = 0, n_fail = 0;
    logic [W-1:0] obs[$];
    logic [W-1:0] exp_q[$];
    logic [31:0]  prog[$];
    int           exp_pc;

    pipelined_risc_v_core_p #(.WIDTH(W), .NREG(NR), .PM_AW(AW)) dut (
        .clk(clk), .rst(rst), .run(run), .load_valid(load_valid),
        .load_byte(load_byte), .load_ready(load_ready), .pc(pc),
        .result(result), .wb_valid(wb_valid), .halted(halted)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (wb_valid) obs.push_back(result);

    task automatic chk(input string tag, input longint got, input longint want);
        n_chk++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", tag, got, want);
        end
    endtask

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [4:0] rd);
        return {imm, rs1, 3'b000, rd, 7'b0010011};
    endfunction

    function automatic logic [31:0] enc_b(input logic bne, input logic [4:0] rs1,
                                          input logic [4:0] rs2, input logic [6:0] tgt);
        return {tgt, rs2, rs1, 2'b00, bne, 5'd0, 7'b1100011};
    endfunction

    // small register pool (x0..x3) with random upper index bit to hit masking
    function automatic logic [4:0] rreg();
        return 5'($urandom_range(0, 3)) | (5'($urandom_range(0, 1)) << 4);
    endfunction

    // ISA interpreter: expected write sequence and final frozen pc
    task automatic model();
        logic [W-1:0] x [NR];
        logic [31:0]  w, imm32;
        logic [W-1:0] a, b, v;
        logic         wr, jmp;
        int           p, rd;
        foreach (x[i]) x[i] = '0;
        exp_q.delete();
        exp_pc = -1;
        p = 0;
        for (int step = 0; step < 2000; step++) begin
            w     = (p < prog.size()) ? prog[p] : 32'h0;
            a     = x[w[19:15] % NR];
            b     = x[w[24:20] % NR];
            rd    = w[11:7] % NR;
            imm32 = 32'($signed(w[31:20]));
            wr    = 1'b0;
            jmp   = 1'b0;
            v     = '0;
            if (w[6:0] == 7'h7F) begin
                exp_pc = (p + 1) % (1 << AW);
                break;
            end
            case (w[6:0])
                7'h33: begin
                    wr = 1'b1;
                    case (w[14:12])
                        3'd0: if (w[31:25] == 7'h00) v = a + b;
                              else if (w[31:25] == 7'h20) v = a - b;
                              else wr = 1'b0;
                        3'd1: v = a << (b % W);
                        3'd4: v = a ^ b;
                        3'd5: v = a >> (b % W);
                        3'd6: v = a | b;
                        3'd7: v = a & b;
                        default: wr = 1'b0;
                    endcase
                end
                7'h13: if (w[14:12] == 3'd0) begin
                    wr = 1'b1;
                    v  = a + imm32[W-1:0];
                end
                7'h63: jmp = (w[14:12] == 3'd0 && a == b) || (w[14:12] == 3'd1 && a != b);
                default: ;
            endcase
            if (wr && rd != 0) begin
                x[rd] = v;
                exp_q.push_back(v);
            end
            p = jmp ? (w[31:25] % (1 << AW)) : (p + 1) % (1 << AW);
        end
    endtask

    // random program ending in HALT; branches only jump forward
    task automatic gen(input int len, input bit br);
        logic [31:0] t;
        prog.delete();
        for (int i = 0; i < len - 1; i++) begin
            int k = $urandom_range(0, br ? 9 : 7);
            logic [2:0] f3 = 3'($urandom_range(0, 7));
            int r = $urandom_range(0, 3);
            case (k)
                0, 1, 2: prog.push_back(enc_i(12'($urandom), rreg(), rreg()));
                3, 4, 5: prog.push_back(enc_r(r == 0 ? 7'h20 : (r == 1 ? 7'h01 : 7'h00),
                                              rreg(), rreg(), f3, rreg()));
                6: begin
                    t = $urandom();
                    t[6:0] = 7'b0001111;
                    prog.push_back(t);
                end
                7: prog.push_back({12'($urandom), rreg(), 3'($urandom_range(1, 7)),
                                   rreg(), 7'h13});
                default: prog.push_back(enc_b(k == 9, rreg(), rreg(),
                                              7'($urandom_range(i + 1, len - 1))));
            endcase
        end
        prog.push_back(HALT);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        run = 1'b0;
        load_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    task automatic lw(input logic [31:0] w);
        for (int i = 0; i < 4; i++) begin
            load_valid = 1'b1;
            load_byte  = w[8*i +: 8];
            @(posedge clk);
            #1;
        end
        load_valid = 1'b0;
    endtask

    task automatic load_prog();
        do_reset();
        foreach (prog[i]) lw(prog[i]);
    endtask

    task automatic start_run();
        obs.delete();
        run = 1'b1;
    endtask

    task automatic wait_halt(input int budget);
        int n = 0;
        while (!halted && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("halt_to", halted, 1);
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1 run = 1'b0;
    endtask

    task automatic compare(input string tag);
        chk({tag, ".n"}, obs.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < obs.size(); i++)
            chk($sformatf("%s.r%0d", tag, i), obs[i], exp_q[i]);
        chk({tag, ".pc"}, pc, exp_pc);
    endtask

    task automatic run_check(input string tag);
        model();
        start_run();
        wait_halt(4 * prog.size() + 20);
        compare(tag);
    endtask

    initial begin
        // reset state
        do_reset();
        @(negedge clk);
        chk("rst.pc", pc, 0);
        chk("rst.res", result, 0);
        chk("rst.wbv", wb_valid, 0);
        chk("rst.halt", halted, 0);
        chk("rst.lrdy", load_ready, 1);

        // basic forward: 5, 7, 12
        prog = '{enc_i(12'd5, 5'd0, 5'd1), enc_i(12'd7, 5'd0, 5'd2),
                 enc_r(7'h00, 5'd2, 5'd1, 3'd0, 5'd3), HALT};
        load_prog();
        run_check("fwd");

        // 8-bit wrap: FF then 01
        prog = '{enc_i(12'hFFF, 5'd0, 5'd1), enc_i(12'd2, 5'd1, 5'd1), HALT};
        load_prog();
        run_check("wrap");

        // taken branch: one bubble, skipped ADDI never commits
        prog = '{enc_b(1'b0, 5'd0, 5'd0, 7'd5), enc_i(12'd9, 5'd0, 5'd4), 32'h0, 32'h0,
                 32'h0, enc_i(12'd3, 5'd4, 5'd5), HALT};
        load_prog();
        model();
        start_run();
        @(negedge clk);
        @(negedge clk);
        chk("br.pc1", pc, 1);
        chk("br.lrdy", load_ready, 0);
        @(negedge clk);
        chk("br.pc5", pc, 5);
        wait_halt(40);
        compare("br");

        // freeze mid-program, then resume
        gen(12, 1'b0);
        prog[0] = enc_i(12'($urandom), 5'd0, 5'd1);
        prog[1] = enc_i(12'($urandom), 5'd1, 5'd2);
        load_prog();
        model();
        start_run();
        repeat (3) @(posedge clk);
        #1 run = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk($sformatf("frz.pc%0d", i), pc, 3);
            chk($sformatf("frz.res%0d", i), result, exp_q[1]);
            chk($sformatf("frz.halt%0d", i), halted, 0);
            chk($sformatf("frz.wbv%0d", i), wb_valid, 0);
        end
        run = 1'b1;
        wait_halt(80);
        compare("frz");

        // partial word discarded by a run pulse
        do_reset();
        load_valid = 1'b1;
        load_byte  = 8'hAA;
        @(posedge clk);
        #1 load_byte = 8'hBB;
        @(posedge clk);
        #1 load_valid = 1'b0;
        run = 1'b1;
        @(posedge clk);
        #1 run = 1'b0;
        lw(enc_i(12'h02A, 5'd0, 5'd1));
        lw(HALT);
        prog = '{enc_i(12'h02A, 5'd0, 5'd1), HALT};
        do_reset();
        run_check("part");

        // reset mid-program, then rerun
        gen(16, 1'b0);
        load_prog();
        model();
        start_run();
        repeat (4) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("mrst.pc", pc, 0);
        chk("mrst.res", result, 0);
        chk("mrst.halt", halted, 0);
        chk("mrst.wbv", wb_valid, 0);
        run = 1'b0;
        rst = 1'b1;
        start_run();
        wait_halt(100);
        compare("mrst");

        // random programs with forward branches
        for (int it = 0; it < 8; it++) begin
            gen($urandom_range(8, 24), 1'b1);
            load_prog();
            run_check($sformatf("rnd%0d", it));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
